// File: rtl/rvfi_shadow_pipe.sv
// Shadow pipeline that walks per-instruction RVFI side-band data from capture to
// writeback, emitting one commit pulse per instruction, a commit order and a halt flag.
module rvfi_shadow_pipe #(
   parameter int DEPTH       = 2,
   parameter int PAYLOAD_W   = 160,
   parameter int ORDER_W     = 64,
   parameter int HALT_REPEAT = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [PAYLOAD_W-1:0] in_payload,
   input  logic [31:0]          in_pc_rdata,
   input  logic [31:0]          in_pc_wdata,
   input  logic [DEPTH-1:0]     adv,
   input  logic [DEPTH-1:0]     flush,
   input  logic                 retire,
   output logic                 out_valid,
   output logic [PAYLOAD_W-1:0] out_payload,
   output logic [31:0]          out_pc_rdata,
   output logic [31:0]          out_pc_wdata,
   output logic                 commit,
   output logic [ORDER_W-1:0]   order,
   output logic                 halt
);

   localparam int CNT_W = $clog2(HALT_REPEAT + 1);

   logic                 valid_q   [DEPTH];
   logic [PAYLOAD_W-1:0] payload_q [DEPTH];
   logic [31:0]          pc_r_q    [DEPTH];
   logic [31:0]          pc_w_q    [DEPTH];

   logic               done_q;
   logic [ORDER_W-1:0] order_q;
   logic [CNT_W-1:0]   loop_cnt_q;
   logic [CNT_W-1:0]   cnt_inc;
   logic               halt_q;
   logic               self_loop;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
         if (i == 0) begin : g_head
            always_ff @(posedge clk) begin
               if (rst) begin
                  valid_q[0]   <= 1'b0;
                  payload_q[0] <= '0;
                  pc_r_q[0]    <= '0;
                  pc_w_q[0]    <= '0;
               end else if (flush[0]) begin
                  valid_q[0] <= 1'b0;
               end else if (adv[0]) begin
                  valid_q[0]   <= in_valid;
                  payload_q[0] <= in_payload;
                  pc_r_q[0]    <= in_pc_rdata;
                  pc_w_q[0]    <= in_pc_wdata;
               end
            end
         end else begin : g_body
            // A held upstream entry is copied as a bubble so it never sits in two stages.
            always_ff @(posedge clk) begin
               if (rst) begin
                  valid_q[i]   <= 1'b0;
                  payload_q[i] <= '0;
                  pc_r_q[i]    <= '0;
                  pc_w_q[i]    <= '0;
               end else if (flush[i]) begin
                  valid_q[i] <= 1'b0;
               end else if (adv[i]) begin
                  valid_q[i]   <= adv[i-1] ? valid_q[i-1] : 1'b0;
                  payload_q[i] <= payload_q[i-1];
                  pc_r_q[i]    <= pc_r_q[i-1];
                  pc_w_q[i]    <= pc_w_q[i-1];
               end
            end
         end
      end
   endgenerate

   assign out_valid    = valid_q[DEPTH-1];
   assign out_payload  = payload_q[DEPTH-1];
   assign out_pc_rdata = pc_r_q[DEPTH-1];
   assign out_pc_wdata = pc_w_q[DEPTH-1];

   // Handshake: out_valid offers the output entry, retire accepts it; the entry
   // commits in the cycle both are high, at most once until the stage reloads.
   assign commit = out_valid & retire & ~done_q;
   assign order  = order_q;
   assign halt   = halt_q;

   assign self_loop = (out_pc_wdata == out_pc_rdata) && (out_pc_rdata != 32'd0);
   assign cnt_inc   = (loop_cnt_q == CNT_W'(HALT_REPEAT)) ? loop_cnt_q
                                                          : loop_cnt_q + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         done_q     <= 1'b0;
         order_q    <= '0;
         loop_cnt_q <= '0;
         halt_q     <= 1'b0;
      end else begin
         if (flush[DEPTH-1] || adv[DEPTH-1]) begin
            done_q <= 1'b0;
         end else if (commit) begin
            done_q <= 1'b1;
         end
         if (commit) begin
            order_q <= order_q + ORDER_W'(1);
            if (self_loop) begin
               loop_cnt_q <= cnt_inc;
               if (cnt_inc == CNT_W'(HALT_REPEAT)) begin
                  halt_q <= 1'b1;
               end
            end else begin
               loop_cnt_q <= '0;
            end
         end
      end
   end

endmodule
